mux16_rr_sched: RTL and testbench

Round-robin scheduler that shares the 16-to-1 structural mux between 16 requesters. It arbitrates a 16-bit request vector and drives the mux select. It registers the selected mux output bit and reports which channel owns the mux. It sits directly in front of mux16to1struct: sel drives its sel input, and its out returns on mux_out.

---
 rtl/mux16_rr_sched.sv | 120 ++++++++++++
 tb/tb_mux16_rr_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin scheduler driving the select of a shared 16:1 mux
module mux16_rr_sched #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic        mux_out,
   output logic [3:0]  sel,
   output logic [15:0] gnt,
   output logic        gnt_valid,
   output logic        data_q,
   output logic        data_valid
);

   localparam int N  = 16;
   localparam int CW = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q, state_d;
   logic [3:0]    sel_q, sel_d;
   logic [3:0]    last_q, last_d;
   logic [15:0]   gnt_q, gnt_d;
   logic          gnt_valid_q, gnt_valid_d;
   logic          data_d;
   logic          data_valid_q, data_valid_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;

   logic          found;
   logic [3:0]    winner;
   logic [3:0]    idx;

   // Round-robin pick: first request set scanning upward from last+1, wrapping;
   // the comparison against 1'b1 makes unknown request bits lose
   always_comb begin
      found  = 1'b0;
      winner = 4'h0;
      idx    = 4'h0;
      for (int k = 1; k <= N; k++) begin
         idx = last_q + 4'(k);
         if (!found && req[idx] == 1'b1) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Next-state and registered-output logic for the IDLE/GRANT controller
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      gnt_d        = gnt_q;
      gnt_valid_d  = gnt_valid_q;
      data_d       = data_q;
      data_valid_d = data_valid_q;
      hold_cnt_d   = hold_cnt_q;
      case (state_q)
         IDLE: begin
            gnt_d        = 16'h0000;
            gnt_valid_d  = 1'b0;
            data_valid_d = 1'b0;
            if (found) begin
               state_d     = GRANT;
               sel_d       = winner;
               last_d      = winner;
               gnt_d       = 16'h0001 << winner;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = CW'(1);
            end
         end
         GRANT: begin
            // A dropped request and an expired hold collapse into one release;
            // the counter never passes HOLD_LIM, so it saturates by construction
            if (req[sel_q] == 1'b1 && hold_cnt_q != HOLD_LIM) begin
               data_d       = mux_out;
               data_valid_d = 1'b1;
               hold_cnt_d   = hold_cnt_q + 1'b1;
            end else begin
               state_d      = IDLE;
               gnt_d        = 16'h0000;
               gnt_valid_d  = 1'b0;
               data_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= 4'h0;
         last_q       <= 4'hF;
         gnt_q        <= 16'h0000;
         gnt_valid_q  <= 1'b0;
         data_q       <= 1'b0;
         data_valid_q <= 1'b0;
         hold_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         gnt_q        <= gnt_d;
         gnt_valid_q  <= gnt_valid_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   assign sel        = sel_q;
   assign gnt        = gnt_q;
   assign gnt_valid  = gnt_valid_q;
   assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb/tb_mux16_rr_sched.sv - self-checking bench for mux16_rr_sched
module tb_mux16_rr_sched;

   localparam int HOLD_MAX = 8;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] mux_a;
   logic        mux_out;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic        data_q;
   logic        data_valid;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_grant, m_gv, m_dv, m_dq;
   int m_sel, m_last, m_hold;

   mux16_rr_sched #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mux_out(mux_out),
      .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid),
      .data_q(data_q), .data_valid(data_valid)
   );

   assign mux_out = mux_a[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      m_grant = 0; m_gv = 0; m_dv = 0; m_dq = 0;
      m_sel = 0; m_last = 15; m_hold = 0;
   endtask

   // winner = requester with the smallest circular distance past the last winner
   function automatic int rr_pick(input logic [15:0] r, input int last);
      int best, bestd, d;
      best = -1; bestd = 99;
      for (int i = 0; i < 16; i++) begin
         if (r[i] === 1'b1) begin
            d = (i - last + 15) % 16;
            if (d < bestd) begin bestd = d; best = i; end
         end
      end
      return best;
   endfunction

   task automatic model_edge();
      int w;
      if (m_grant) begin
         if (req[m_sel] !== 1'b1 || m_hold == HOLD_MAX) begin
            m_grant = 0; m_gv = 0; m_dv = 0;
         end else begin
            m_dq = mux_a[m_sel]; m_dv = 1; m_hold++;
         end
      end else begin
         w = rr_pick(req, m_last);
         if (w >= 0) begin
            m_grant = 1; m_gv = 1; m_sel = w; m_last = w; m_hold = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req = '0; model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; req = '0; mux_a = '0;
      #3 rst_n = 1'b0; model_reset();
      #1;
      checks++; if (sel !== 4'h0) begin errors++; $display("FAIL reset_sel: got %0h expected 0", sel); end
      checks++; if (gnt !== 16'h0) begin errors++; $display("FAIL reset_gnt: got %0h expected 0", gnt); end
      checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %0b expected 0", gnt_valid); end
      checks++; if (data_valid !== 1'b0 || data_q !== 1'b0) begin errors++; $display("FAIL reset_data: got dv=%0b dq=%0b expected 0 0", data_valid, data_q); end
      @(negedge clk); rst_n = 1'b1;
      req = 16'h0040; step();
      checks++; if (sel !== 4'd6 || gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_grant: got sel=%0d gv=%0b expected 6 1", sel, gnt_valid); end
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sel !== 4'h0 || gnt !== 16'h0) begin errors++; $display("FAIL reset_mid_grant: got sel=%0d gnt=%0h expected 0 0", sel, gnt); end
      checks++; if (gnt_valid !== 1'b0 || data_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got gv=%0b dv=%0b expected 0 0", gnt_valid, data_valid); end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      req = 16'h0001; step();
      checks++; if (sel !== 4'd0 || gnt !== 16'h0001 || gnt_valid !== 1'b1) begin errors++; $display("FAIL reset_regrant0: got sel=%0d gnt=%0h gv=%0b expected 0 1 1", sel, gnt, gnt_valid); end
      req = '0; step(); step();
   endtask

   task automatic test_single();
      do_reset();
      mux_a = 16'h3f0a; req = 16'h0002; step();
      checks++; if (sel !== 4'd1 || gnt !== 16'h0002 || gnt_valid !== 1'b1) begin errors++; $display("FAIL single_grant: got sel=%0d gnt=%0h gv=%0b expected 1 2 1", sel, gnt, gnt_valid); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL single_dv_early: got %0b expected 0", data_valid); end
      step();
      checks++; if (data_q !== 1'b1 || data_valid !== 1'b1) begin errors++; $display("FAIL single_data: got dq=%0b dv=%0b expected 1 1", data_q, data_valid); end
      req = '0; step();
      checks++; if (gnt_valid !== 1'b0 || gnt !== 16'h0 || data_valid !== 1'b0) begin errors++; $display("FAIL single_release: got gv=%0b gnt=%0h dv=%0b expected 0 0 0", gnt_valid, gnt, data_valid); end
      checks++; if (sel !== 4'd1 || data_q !== 1'b1) begin errors++; $display("FAIL single_hold: got sel=%0d dq=%0b expected 1 1", sel, data_q); end
      step();
   endtask

   // observe grants for ncyc cycles: winners, grant lengths, bubble lengths
   task automatic observe(input int ncyc, output int starts[$], output int lens[$], output int gaps[$]);
      bit prev; int run, idle;
      starts = {}; lens = {}; gaps = {};
      prev = 0; run = 0; idle = 0;
      for (int c = 0; c < ncyc; c++) begin
         step();
         if (gnt_valid === 1'b1) begin
            if (!prev) begin
               starts.push_back(int'(sel));
               if (starts.size() > 1) gaps.push_back(idle);
            end
            run++; idle = 0;
         end else begin
            if (prev) begin lens.push_back(run); run = 0; end
            idle++;
         end
         prev = (gnt_valid === 1'b1);
      end
   endtask

   task automatic test_round_robin();
      int starts[$], lens[$], gaps[$];
      int exp_order[4] = '{0, 6, 12, 0};
      do_reset();
      req = 16'h1041;
      observe(40, starts, lens, gaps);
      checks++;
      if (starts.size() < 4 || lens.size() < 3 || gaps.size() < 3) begin
         errors++; $display("FAIL rr_count: got %0d grants expected at least 4", starts.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (starts[i] != exp_order[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, starts[i], exp_order[i]); end
         end
         for (int i = 0; i < 3; i++) begin
            checks++; if (lens[i] != HOLD_MAX) begin errors++; $display("FAIL rr_len[%0d]: got %0d expected %0d", i, lens[i], HOLD_MAX); end
            checks++; if (gaps[i] != 1) begin errors++; $display("FAIL rr_bubble[%0d]: got %0d expected 1", i, gaps[i]); end
         end
      end
      req = '0; step(); step();
   endtask

   task automatic test_wrap();
      int starts[$], lens[$], gaps[$];
      int exp_order[3] = '{0, 15, 0};
      do_reset();
      req = 16'h8000; step();
      checks++; if (sel !== 4'd15 || gnt !== 16'h8000) begin errors++; $display("FAIL wrap_setup: got sel=%0d gnt=%0h expected 15 8000", sel, gnt); end
      req = '0; step(); step();
      req = 16'h8001;
      observe(30, starts, lens, gaps);
      checks++;
      if (starts.size() < 3) begin
         errors++; $display("FAIL wrap_count: got %0d grants expected at least 3", starts.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (starts[i] != exp_order[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, starts[i], exp_order[i]); end
         end
      end
      req = '0; step(); step();
   endtask

   task automatic test_data();
      int picks[4] = '{0, 1, 6, 12};
      bit pexp[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int n;
      do_reset();
      mux_a = 16'h3f0a;
      for (int j = 0; j < 20; j++) begin
         int i;
         i = (j < 4) ? picks[j] : j - 4;
         req = 16'h0001 << i;
         n = 0;
         do begin step(); n++; end while (data_valid !== 1'b1 && n < 4);
         checks++;
         if (data_valid !== 1'b1) begin
            errors++; $display("FAIL data_timeout[%0d]: got dv=%0b expected 1", i, data_valid);
         end else if (j < 4) begin
            if (data_q !== pexp[j]) begin errors++; $display("FAIL data_pick[%0d]: got %0b expected %0b", i, data_q, pexp[j]); end
         end else begin
            if (data_q !== mux_a[i] || sel !== 4'(i)) begin errors++; $display("FAIL data_idx[%0d]: got dq=%0b sel=%0d expected %0b %0d", i, data_q, sel, mux_a[i], i); end
         end
         req = '0; step(); step();
      end
   endtask

   task automatic test_sim_drop();
      int rises;
      bit prev;
      do_reset();
      req = 16'h0008; step();
      checks++; if (sel !== 4'd3 || gnt_valid !== 1'b1) begin errors++; $display("FAIL drop_setup: got sel=%0d gv=%0b expected 3 1", sel, gnt_valid); end
      req = 16'h0028;
      for (int c = 0; c < HOLD_MAX - 1; c++) begin
         step();
         checks++; if (sel !== 4'd3 || gnt !== 16'h0008 || gnt_valid !== 1'b1) begin errors++; $display("FAIL drop_nopreempt[%0d]: got sel=%0d gnt=%0h gv=%0b expected 3 8 1", c, sel, gnt, gnt_valid); end
      end
      req = 16'h0020; step();
      checks++; if (gnt_valid !== 1'b0 || gnt !== 16'h0) begin errors++; $display("FAIL drop_release: got gv=%0b gnt=%0h expected 0 0", gnt_valid, gnt); end
      step();
      checks++; if (sel !== 4'd5 || gnt !== 16'h0020 || gnt_valid !== 1'b1) begin errors++; $display("FAIL drop_next: got sel=%0d gnt=%0h gv=%0b expected 5 20 1", sel, gnt, gnt_valid); end
      rises = 0; prev = 1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (gnt_valid === 1'b1 && !prev) rises++;
         prev = (gnt_valid === 1'b1);
      end
      checks++; if (rises != 0) begin errors++; $display("FAIL drop_glitch: got %0d extra grants expected 0", rises); end
      req = '0; step(); step();
   endtask

   task automatic test_random();
      logic [15:0] exp_gnt;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0: req = '0;
               1: req = 16'h0001 << $urandom_range(0, 15);
               2: req = 16'($urandom);
               default: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            endcase
         end
         if ($urandom_range(0, 9) == 0) mux_a = 16'($urandom);
         step();
         exp_gnt = m_gv ? (16'h0001 << m_sel) : 16'h0000;
         checks++; if (sel !== 4'(m_sel)) begin errors++; $display("FAIL rand_sel@%0d: got %0d expected %0d", c, sel, m_sel); end
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt@%0d: got %0h expected %0h", c, gnt, exp_gnt); end
         checks++; if (gnt_valid !== m_gv) begin errors++; $display("FAIL rand_gv@%0d: got %0b expected %0b", c, gnt_valid, m_gv); end
         checks++; if (data_valid !== m_dv) begin errors++; $display("FAIL rand_dv@%0d: got %0b expected %0b", c, data_valid, m_dv); end
         checks++; if (data_q !== m_dq) begin errors++; $display("FAIL rand_dq@%0d: got %0b expected %0b", c, data_q, m_dq); end
      end
      req = '0; step(); step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_data();
      test_sim_drop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
